// File: rtl/uart_rx_deserializer.sv
// UART receive front end: 2-flop sync, start detect,
// LSB-first shift, stop check, one word strobe per frame.
module uart_rx_deserializer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] HALF_M1 =
    CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 =
    CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t               state, state_n;
  logic                 sync1, rx_s;
  logic [CNT_W-1:0]     clk_cnt, cnt_n;
  logic [IDX_W-1:0]     bit_idx, idx_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [DATA_BITS-1:0] data_n;
  logic                 valid_n, ferr_n;

  // two-flop synchroniser, reset to idle-high line
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx_serial;
      rx_s  <= sync1;
    end
  end

  // state, counters, shift register and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_n;
      clk_cnt     <= cnt_n;
      bit_idx     <= idx_n;
      shift       <= shift_n;
      rx_data     <= data_n;
      rx_valid    <= valid_n;
      frame_error <= ferr_n;
    end
  end

  // next-state and datapath update; clear aborts the frame
  always_comb begin
    state_n = state;
    cnt_n   = clk_cnt;
    idx_n   = bit_idx;
    shift_n = shift;
    data_n  = rx_data;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    if (clear) begin
      state_n = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state_n = S_START;
            cnt_n   = '0;
          end
        end
        S_START: begin
          if (clk_cnt == HALF_M1) begin
            cnt_n = '0;
            if (rx_s) begin
              state_n = S_IDLE;
            end else begin
              state_n = S_DATA;
              idx_n   = '0;
            end
          end else begin
            cnt_n = clk_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (clk_cnt == FULL_M1) begin
            cnt_n = '0;
            for (int i = 0; i < DATA_BITS; i++) begin
              if (bit_idx == IDX_W'(i)) shift_n[i] = rx_s;
            end
            if (bit_idx == LAST_IDX) begin
              state_n = S_STOP;
            end else begin
              idx_n = bit_idx + IDX_W'(1);
            end
          end else begin
            cnt_n = clk_cnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (clk_cnt == FULL_M1) begin
            cnt_n = '0;
            if (rx_s) begin
              data_n  = shift;
              valid_n = 1'b1;
              state_n = S_IDLE;
            end else begin
              ferr_n  = 1'b1;
              state_n = S_BREAK;
            end
          end else begin
            cnt_n = clk_cnt + CNT_W'(1);
          end
        end
        S_BREAK: begin
          if (rx_s) state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);

endmodule
